// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants for the Morse display scheduler
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCROLL = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam int         WIN_W     = 4;

endpackage

// File: rtl/morse_scroll_ctrl_if.sv
// rtl/morse_scroll_ctrl_if.sv - letter input and display output bundle
interface morse_scroll_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [6:0]    SymD;
    logic          SymV;
    logic          Clr;
    logic [6:0]    SegY;
    logic [3:0]    DigY;
    logic [CW-1:0] Cnt;
    logic          Ovf;
    logic [1:0]    StateY;

    modport master (
        output SymD, SymV, Clr,
        input  SegY, DigY, Cnt, Ovf, StateY
    );

    modport slave (
        input  SymD, SymV, Clr,
        output SegY, DigY, Cnt, Ovf, StateY
    );

endinterface

// File: rtl/morse_sym_fifo.sv
// rtl/morse_sym_fifo.sv - letter FIFO with flush and simultaneous push/pop
module morse_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 7,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_acc;
    logic          pop_acc;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rd_q];
    assign cnt   = cnt_q;

    // Accept a push on a full FIFO only when a pop frees the slot in the same cycle
    always_comb begin
        pop_acc  = pop && !empty && !clr;
        push_acc = push && (!full || pop_acc) && !clr;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_acc) wr_d = wr_q + 1'b1;
            if (pop_acc)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(push_acc) - CW'(pop_acc);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Letter storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/morse_scroll_ctrl.sv
// rtl/morse_scroll_ctrl.sv - scrolls buffered letters across a 4-digit muxed display
module morse_scroll_ctrl
    import morse_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TICK   = 12_500_000,
    parameter int MUXDIV = 50_000
) (
    input  logic               C,
    input  logic               aR,
    morse_scroll_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TICK);
    localparam int MW = (MUXDIV > 1) ? $clog2(MUXDIV) : 1;

    state_e                  state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [2:0]              blank_q, blank_d;
    logic [WIN_W-1:0][6:0]   win_q, win_d;
    logic                    ovf_q, ovf_d;
    logic [MW-1:0]           ref_q, ref_d;
    logic [1:0]              idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;

    logic                    tick;
    logic                    pop;
    logic                    shift_en;
    logic [6:0]              shift_val;
    logic [6:0]              fifo_rdata;
    logic [CW-1:0]           fifo_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;

    morse_sym_fifo #(
        .DEPTH (DEPTH),
        .W     (7),
        .CW    (CW)
    ) u_fifo (
        .clk   (C),
        .rst_n (aR),
        .clr   (bus.Clr),
        .push  (bus.SymV),
        .pop   (pop),
        .wdata (bus.SymD),
        .rdata (fifo_rdata),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tick = (state_q != ST_IDLE) && (tick_q == TW'(TICK - 1));

    // FSM state register
    always_ff @(posedge C or negedge aR) begin
        if (!aR) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: HOLD returns to IDLE once the fourth blank has been shifted in
    always_comb begin
        state_d = state_q;
        if (bus.Clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (!fifo_empty) state_d = ST_SCROLL;
                ST_SCROLL: if (tick && fifo_empty) state_d = ST_HOLD;
                ST_HOLD: begin
                    if (tick) begin
                        if (!fifo_empty)          state_d = ST_SCROLL;
                        else if (blank_q == 3'd3) state_d = ST_IDLE;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: pop/shift decisions, tick and blank counters, window, overflow flag
    always_comb begin
        pop       = 1'b0;
        shift_en  = 1'b0;
        shift_val = fifo_rdata;
        tick_d    = tick_q;
        blank_d   = blank_q;
        if (bus.Clr) begin
            tick_d  = '0;
            blank_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tick_d = '0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_en = 1'b1;
                    end
                end
                ST_SCROLL, ST_HOLD: begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (tick) begin
                        shift_en = 1'b1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            blank_d = '0;
                        end else begin
                            shift_val = SEG_BLANK;
                            blank_d   = (state_q == ST_SCROLL) ? 3'd1 : blank_q + 3'd1;
                        end
                    end
                end
                default: tick_d = '0;
            endcase
        end

        win_d = win_q;
        if (bus.Clr)       win_d = {WIN_W{SEG_BLANK}};
        else if (shift_en) win_d = {win_q[WIN_W-2:0], shift_val};

        ovf_d = bus.Clr ? 1'b0 : (ovf_q | (bus.SymV && fifo_full && !pop));
    end

    // Scroll datapath registers
    always_ff @(posedge C or negedge aR) begin
        if (!aR) begin
            tick_q  <= '0;
            blank_q <= '0;
            win_q   <= {WIN_W{SEG_BLANK}};
            ovf_q   <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            blank_q <= blank_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
        end
    end

    // Refresh mux: free-running, ignores Clr; segments follow the digit being enabled
    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == MW'(MUXDIV - 1)) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
        seg_d = win_q[idx_d];
    end

    // Refresh mux registers
    always_ff @(posedge C or negedge aR) begin
        if (!aR) begin
            ref_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
        end
    end

    assign bus.SegY   = seg_q;
    assign bus.DigY   = 4'b0001 << idx_q;
    assign bus.Cnt    = fifo_cnt;
    assign bus.Ovf    = ovf_q;
    assign bus.StateY = state_q;

endmodule

// File: tb/tb_morse_scroll_ctrl.sv
// tb/tb_morse_scroll_ctrl.sv - scoreboard bench for the Morse display scheduler
module tb_morse_scroll_ctrl;

    localparam int DEPTH  = 4;
    localparam int TICK   = 8;
    localparam int MUXDIV = 2;

    logic C  = 1'b0;
    logic aR = 1'b0;

    morse_scroll_ctrl_if #(.DEPTH(DEPTH)) bus ();

    morse_scroll_ctrl #(
        .DEPTH  (DEPTH),
        .TICK   (TICK),
        .MUXDIV (MUXDIV)
    ) dut (
        .C   (C),
        .aR  (aR),
        .bus (bus)
    );

    always #5 C = ~C;

    typedef struct {
        int         k;
        logic [6:0] seg;
        logic [3:0] dig;
        int         cnt;
        logic       ovf;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: letters queue, window W0..W3, state 0/1/2, cycles since last tick
    logic [6:0] m_fifo[$];
    logic [6:0] m_win[4];
    logic [6:0] m_prev[4];
    int         m_st;
    int         m_phase;
    int         m_blanks;
    bit         m_ovf;
    int         m_k;

    task automatic chk(input string name, input int act, input int expv, input int k);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s cycle=%0d: got %0d expected %0d", name, k, act, expv);
    endtask

    function automatic void m_reset();
        m_fifo.delete();
        for (int i = 0; i < 4; i++) begin
            m_win[i]  = 7'd0;
            m_prev[i] = 7'd0;
        end
        m_st = 0; m_phase = 0; m_blanks = 0; m_ovf = 1'b0; m_k = 0;
    endfunction

    function automatic void m_shift(input logic [6:0] v);
        m_win[3] = m_win[2];
        m_win[2] = m_win[1];
        m_win[1] = m_win[0];
        m_win[0] = v;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        int   idx;
        idx   = (m_k / MUXDIV) % 4;
        e.k   = m_k;
        e.seg = m_prev[idx];
        e.dig = 4'(1 << idx);
        e.cnt = m_fifo.size();
        e.ovf = m_ovf;
        e.st  = 2'(m_st);
        return e;
    endfunction

    function automatic void m_step(input bit v, input logic [6:0] d, input bit clr);
        int n;
        bit popped;
        bit tk;
        m_prev = m_win;
        m_k++;
        if (clr) begin
            m_fifo.delete();
            for (int i = 0; i < 4; i++) m_win[i] = 7'd0;
            m_st = 0; m_phase = 0; m_blanks = 0; m_ovf = 1'b0;
            return;
        end
        n      = m_fifo.size();
        popped = 1'b0;
        if (m_st == 0) begin
            m_phase = 0;
            if (n != 0) begin
                m_shift(m_fifo.pop_front());
                popped = 1'b1;
                m_st   = 1;
            end
        end else begin
            tk      = (m_phase == TICK - 1);
            m_phase = tk ? 0 : m_phase + 1;
            if (tk) begin
                if (n != 0) begin
                    m_shift(m_fifo.pop_front());
                    popped   = 1'b1;
                    m_st     = 1;
                    m_blanks = 0;
                end else begin
                    m_shift(7'd0);
                    if (m_st == 1) begin
                        m_blanks = 1;
                        m_st     = 2;
                    end else begin
                        m_blanks++;
                        if (m_blanks == 4) m_st = 0;
                    end
                end
            end
        end
        if (v) begin
            if (n < DEPTH || popped) m_fifo.push_back(d);
            else                     m_ovf = 1'b1;
        end
    endfunction

    task automatic cycle(input bit v, input logic [6:0] d, input bit clr);
        bus.SymV = v;
        bus.SymD = d;
        bus.Clr  = clr;
        @(posedge C);
        #1;
        m_step(v, d, clr);
        exp_q.push_back(m_expect());
        bus.SymV = 1'b0;
        bus.Clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 7'd0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        aR = 1'b0;
        m_reset();
        for (int i = 0; i < hold; i++) begin
            @(posedge C);
            #1;
            exp_q.push_back(m_expect());
        end
        @(negedge C);
        #1;
        aR = 1'b1;
    endtask

    // Monitor: every negedge, compare DUT outputs with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge C);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("SegY",   int'(bus.SegY),   int'(e.seg), e.k);
                chk("DigY",   int'(bus.DigY),   int'(e.dig), e.k);
                chk("Cnt",    int'(bus.Cnt),    e.cnt,       e.k);
                chk("Ovf",    int'(bus.Ovf),    int'(e.ovf), e.k);
                chk("StateY", int'(bus.StateY), int'(e.st),  e.k);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int hit;
        bus.SymV = 1'b0;
        bus.SymD = 7'd0;
        bus.Clr  = 1'b0;

        do_reset(3);

        // Single letter at cycle 10, then let it scroll off fully
        idle(9);
        cycle(1'b1, 7'h4F, 1'b0);
        idle(40);

        // Overflow burst in SCROLL with no tick pending, then flush
        cycle(1'b1, 7'h11, 1'b0);
        idle(2);
        for (int i = 0; i < 6; i++) cycle(1'b1, 7'(8'h20 + i), 1'b0);
        idle(1);
        cycle(1'b0, 7'd0, 1'b1);
        idle(3);

        // Full FIFO: push coincides with a tick pop
        cycle(1'b1, 7'h31, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) cycle(1'b1, 7'(8'h40 + i), 1'b0);
        hit = 0;
        for (int i = 0; i < 30 && hit == 0; i++) begin
            if (m_st != 0 && m_phase == TICK - 1 && m_fifo.size() == DEPTH) begin
                cycle(1'b1, 7'h5A, 1'b0);
                hit = 1;
            end else begin
                idle(1);
            end
        end
        chk("collision_reached", hit, 1, m_k);
        idle(70);

        // HOLD re-entry after two blanks
        cycle(1'b1, 7'h66, 1'b0);
        hit = 0;
        for (int i = 0; i < 60 && hit == 0; i++) begin
            if (m_st == 2 && m_blanks == 2) begin
                cycle(1'b1, 7'h77, 1'b0);
                hit = 1;
            end else begin
                idle(1);
            end
        end
        chk("hold_reentry_reached", hit, 1, m_k);
        idle(60);

        // Asynchronous reset mid-scroll
        cycle(1'b1, 7'h12, 1'b0);
        cycle(1'b1, 7'h34, 1'b0);
        idle(12);
        @(negedge C);
        #2;
        aR = 1'b0;
        #1;
        chk("async_SegY",   int'(bus.SegY),   0, m_k);
        chk("async_DigY",   int'(bus.DigY),   1, m_k);
        chk("async_Cnt",    int'(bus.Cnt),    0, m_k);
        chk("async_Ovf",    int'(bus.Ovf),    0, m_k);
        chk("async_StateY", int'(bus.StateY), 0, m_k);
        do_reset(1);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 700; i++) begin
            cycle(($urandom_range(0, 3) == 0), 7'($urandom_range(1, 127)),
                  ($urandom_range(0, 99) == 0));
        end
        idle(50);

        hit = 0;
        for (int i = 0; i < 10 && hit == 0; i++) begin
            @(negedge C);
            #1;
            if (exp_q.size() == 0) hit = 1;
        end
        chk("scoreboard_drained", hit, 1, m_k);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
